// File: rtl/vx_launch_ctrl.sv
// vx_launch_ctrl: register-mapped launch sequencer for one Vortex GPU run.
// Holds Vortex in reset while the host owns the shared RAM. A START/GO write
// runs a timed reset hold. It then waits for vx_busy to rise, tracks the kernel
// until busy drops, and ends in DONE or ERROR with a level interrupt.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-low reset
//   reg_sel/reg_wen   one-cycle register access strobe, 1 = write
//   reg_addr/wdata    register address / write data
//   reg_rdata/rvalid  registered read data, valid the cycle after a read strobe
//   vx_reset          active-high reset to Vortex
//   vx_busy           Vortex busy
//   host_mem_grant    host may access shared RAM (IDLE/DONE/ERROR)
//   irq               done | error
//
// Register map: 0xFFFE START (W: bit0 GO, bit1 CLR), 0xFFFF STATUS (R),
//               0xFFFD CYCLES (R), 0xFFFC TIMEOUT (R/W, 0 = disabled).
module vx_launch_ctrl #(
  parameter int unsigned RESET_HOLD = 8,
  parameter int unsigned START_WIN  = 16,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_sel,
  input  logic              reg_wen,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [31:0]       reg_wdata,
  output logic [31:0]       reg_rdata,
  output logic              reg_rvalid,
  output logic              vx_reset,
  input  logic              vx_busy,
  output logic              host_mem_grant,
  output logic              irq
);

  localparam int unsigned HOLD_W = $clog2(RESET_HOLD + 1);
  localparam int unsigned WIN_W  = (START_WIN > 1) ? $clog2(START_WIN) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(START_WIN - 1);

  localparam logic [ADDR_W-1:0] A_START  = ADDR_W'(16'hFFFE);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(16'hFFFF);
  localparam logic [ADDR_W-1:0] A_CYCLES = ADDR_W'(16'hFFFD);
  localparam logic [ADDR_W-1:0] A_TMO    = ADDR_W'(16'hFFFC);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HOLD  = 3'd1,
    S_WAIT  = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [WIN_W-1:0]    win_q, win_d;
  logic [31:0]         cycles_q, cycles_d;
  logic [31:0]         timeout_q, timeout_d;
  logic                busy_low_q, busy_low_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;

  logic        wr_start, go, clr, running, tmo_hit;
  logic [31:0] status_w, rd_word;

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      hold_q     <= '0;
      win_q      <= '0;
      cycles_q   <= '0;
      timeout_q  <= '0;
      busy_low_q <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      win_q      <= win_d;
      cycles_q   <= cycles_d;
      timeout_q  <= timeout_d;
      busy_low_q <= busy_low_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    wr_start   = reg_sel && reg_wen && (reg_addr == A_START);
    go         = wr_start && reg_wdata[0];
    clr        = wr_start && reg_wdata[1];
    tmo_hit    = running && (timeout_q != '0) && (cycles_q == timeout_q);

    state_d    = state_q;
    hold_d     = hold_q;
    win_d      = win_q;
    cycles_d   = cycles_q;
    timeout_d  = timeout_q;
    busy_low_d = ~vx_busy;

    if (reg_sel && reg_wen && (reg_addr == A_TMO)) begin
      timeout_d = reg_wdata;
    end

    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d  = S_HOLD;
          cycles_d = '0;
          hold_d   = HOLD_INIT;
        end
      end
      S_HOLD: begin
        hold_d = hold_q - HOLD_ONE;
        if (hold_q == HOLD_ONE) begin
          state_d = S_WAIT;
          win_d   = '0;
        end
      end
      S_WAIT: begin
        if (vx_busy) begin
          state_d = S_RUN;
        end else if (win_q == WIN_LAST) begin
          state_d = S_ERROR;
        end else begin
          win_d = win_q + 1'b1;
        end
      end
      S_RUN: begin
        // busy_low_q is the previous sample; entering RUN needs busy high,
        // so two lows here are always two lows seen inside RUN.
        if (!vx_busy && busy_low_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE, S_ERROR: begin
        if (go) begin
          state_d  = S_HOLD;
          cycles_d = '0;
          hold_d   = HOLD_INIT;
        end else if (clr) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Timeout overrides every other transition and freezes CYCLES at the match.
    if (tmo_hit) begin
      state_d = S_ERROR;
    end else if (((state_q == S_WAIT) || (state_q == S_RUN)) && (cycles_q != '1)) begin
      cycles_d = cycles_q + 32'd1;
    end

    // Read path samples pre-edge register values.
    case (reg_addr)
      A_STATUS: rd_word = status_w;
      A_CYCLES: rd_word = cycles_q;
      A_TMO:    rd_word = timeout_q;
      default:  rd_word = '0;
    endcase
    rvalid_d = reg_sel && !reg_wen;
    rdata_d  = rvalid_d ? rd_word : rdata_q;
  end

  // Outputs
  always_comb begin
    running        = (state_q == S_HOLD) || (state_q == S_WAIT) || (state_q == S_RUN);
    vx_reset       = !((state_q == S_WAIT) || (state_q == S_RUN));
    host_mem_grant = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);
    irq            = (state_q == S_DONE) || (state_q == S_ERROR);
    status_w       = {25'd0, state_q, vx_busy, (state_q == S_ERROR),
                      (state_q == S_DONE), running};
    reg_rdata      = rdata_q;
    reg_rvalid     = rvalid_q;
  end

endmodule

// File: tb/tb_vx_launch_ctrl.sv
// Self-checking bench for vx_launch_ctrl. Register reads push their expected
// value into a scoreboard; a monitor pops and compares whenever reg_rvalid is
// seen. Stimulus is driven and outputs are sampled on the falling clock edge.
module tb_vx_launch_ctrl;

  localparam logic [15:0] A_START  = 16'hFFFE;
  localparam logic [15:0] A_STATUS = 16'hFFFF;
  localparam logic [15:0] A_CYCLES = 16'hFFFD;
  localparam logic [15:0] A_TMO    = 16'hFFFC;

  logic        clk;
  logic        reset;
  logic        reg_sel;
  logic        reg_wen;
  logic [15:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        reg_rvalid;
  logic        vx_reset;
  logic        vx_busy;
  logic        host_mem_grant;
  logic        irq;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  vx_launch_ctrl #(
    .RESET_HOLD(8),
    .START_WIN (16),
    .ADDR_W    (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .reg_sel       (reg_sel),
    .reg_wen       (reg_wen),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_rdata     (reg_rdata),
    .reg_rvalid    (reg_rvalid),
    .vx_reset      (vx_reset),
    .vx_busy       (vx_busy),
    .host_mem_grant(host_mem_grant),
    .irq           (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Scoreboard monitor: every read-data pulse must match the oldest pending read.
  always @(negedge clk) begin
    if (reg_rvalid === 1'b1) begin
      if (exp_q.size() == 0) check_eq("rvalid_spurious", reg_rvalid, 0);
      else check_eq(tag_q.pop_front(), reg_rdata, exp_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    reg_sel = 1'b1; reg_wen = 1'b1; reg_addr = a; reg_wdata = d;
    @(negedge clk);
    reg_sel = 1'b0; reg_wen = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [31:0] e);
    reg_sel = 1'b1; reg_wen = 1'b0; reg_addr = a;
    tag_q.push_back(tag);
    exp_q.push_back(e);
    @(negedge clk);
    reg_sel = 1'b0;
  endtask

  // which=0: wait for vx_reset low; which=1: wait for irq high. Bounded.
  task automatic wait_for(input int which, input int bound, output int n);
    n = 0;
    while (!((which == 0) ? (vx_reset === 1'b0) : (irq === 1'b1)) && n < bound) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0; reg_sel = 1'b0; reg_wen = 1'b0;
    reg_addr = '0; reg_wdata = '0; vx_busy = 1'b0;
    tick(2);
    reset = 1'b1;

    // Reset state
    check_eq("rst_vxrst",  vx_reset, 1);
    check_eq("rst_grant",  host_mem_grant, 1);
    check_eq("rst_irq",    irq, 0);
    check_eq("rst_rvalid", reg_rvalid, 0);
    check_eq("rst_rdata",  reg_rdata, 0);
    rd("rst_cycles", A_CYCLES, 0);
    rd("rst_tmo",    A_TMO, 0);

    // Register access
    wr(A_TMO, 32'h1234);
    rd("tmo_rd",    A_TMO, 32'h1234);
    rd("unmapped",  16'hFFF0, 0);
    rd("start_rd",  A_START, 0);
    wr(A_STATUS, 32'hFFFF_FFFF);
    wr(16'hFFF0, 32'hABCD);
    rd("st_idle",   A_STATUS, 0);
    rd("cyc_idle",  A_CYCLES, 0);
    wr(A_TMO, 0);

    // Nominal run
    wr(A_START, 1);
    check_eq("go_grant", host_mem_grant, 0);
    check_eq("go_vxrst", vx_reset, 1);
    wait_for(0, 40, n);
    check_eq("hold_len", n, 8);
    tick(3);
    vx_busy = 1'b1;
    tick(40);
    wr(A_START, 32'h3);
    check_eq("run_go_vxrst", vx_reset, 0);
    check_eq("run_go_grant", host_mem_grant, 0);
    rd("st_run", A_STATUS, 32'h39);
    tick(58);
    vx_busy = 1'b0;
    wait_for(1, 10, n);
    check_eq("done_lat",   n, 2);
    check_eq("done_vxrst", vx_reset, 1);
    check_eq("done_grant", host_mem_grant, 1);
    rd("st_done",  A_STATUS, 32'h42);
    rd("cyc_done", A_CYCLES, 105);

    // GO+CLR from DONE restarts, then reset while in HOLD
    wr(A_TMO, 32'h77);
    wr(A_START, 32'h3);
    check_eq("gc_grant", host_mem_grant, 0);
    check_eq("gc_irq",   irq, 0);
    rd("gc_cycles", A_CYCLES, 0);
    rd("st_hold",   A_STATUS, 32'h11);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    check_eq("mrst_vxrst",  vx_reset, 1);
    check_eq("mrst_grant",  host_mem_grant, 1);
    check_eq("mrst_irq",    irq, 0);
    check_eq("mrst_rdata",  reg_rdata, 0);
    check_eq("mrst_rvalid", reg_rvalid, 0);
    rd("mrst_tmo",    A_TMO, 0);
    rd("mrst_cycles", A_CYCLES, 0);
    rd("mrst_status", A_STATUS, 0);

    // Short run, then CLR alone back to IDLE
    wr(A_START, 1);
    wait_for(0, 40, n);
    check_eq("hold_len2", n, 8);
    vx_busy = 1'b1;
    tick(5);
    vx_busy = 1'b0;
    wait_for(1, 10, n);
    check_eq("done_lat2", n, 2);
    wr(A_START, 32'h2);
    check_eq("clr_irq",   irq, 0);
    check_eq("clr_grant", host_mem_grant, 1);
    rd("clr_status", A_STATUS, 0);
    rd("clr_cycles", A_CYCLES, 7);

    // No-start error
    wr(A_START, 1);
    wait_for(0, 40, n);
    wait_for(1, 40, n);
    check_eq("win_len",     n, 16);
    check_eq("nostart_vxrst", vx_reset, 1);
    rd("st_nostart",  A_STATUS, 32'h54);
    rd("cyc_nostart", A_CYCLES, 16);

    // Timeout with busy stuck high, GO straight from ERROR
    wr(A_TMO, 50);
    wr(A_START, 1);
    wait_for(0, 40, n);
    vx_busy = 1'b1;
    wait_for(1, 200, n);
    check_eq("tmo_len", n, 51);
    rd("st_tmo",   A_STATUS, 32'h5C);
    rd("cyc_tmo",  A_CYCLES, 50);
    tick(5);
    rd("cyc_tmo2", A_CYCLES, 50);
    vx_busy = 1'b0;

    tick(3);
    check_eq("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vx_launch_ctrl.md
# vx_launch_ctrl

Register-mapped launch controller that sequences one Vortex GPU run for the host bus. It holds Vortex in reset while the host loads memory. On a START write it pulses a timed reset-release, tracks the `busy` signal through the kernel, counts cycles, enforces an optional timeout and raises a level interrupt at completion. It also tells the memory path when the host may own the shared RAM.

## Interface
- `RESET_HOLD`, 8: cycles `vx_reset` is held after a start before release (≥1).
- `START_WIN`, 16: cycles allowed for `vx_busy` to first rise after release.
- `ADDR_W`, 16: register address width.
- `clk` in 1: clock, all logic rising-edge.
- `reset` in 1: synchronous, active-low reset.
- `reg_sel` in 1: register access strobe, one cycle per access.
- `reg_wen` in 1: 1 = write, 0 = read (qualified by `reg_sel`).
- `reg_addr` in ADDR_W: register address.
- `reg_wdata` in 32: write data.
- `reg_rdata` out 32: read data, registered.
- `reg_rvalid` out 1: one-cycle pulse, the cycle after a read strobe.
- `vx_reset` out 1: active-high reset to Vortex, ORed with system reset upstream.
- `vx_busy` in 1: Vortex busy.
- `host_mem_grant` out 1: host may access shared RAM.
- `irq` out 1: level interrupt, equal to done | error.

## Operation
- Register map:
  - 0xFFFE START, write-only.
    - bit0 GO: start a run.
    - bit1 CLR: clear done/error.
    - Reads return 0.
  - 0xFFFF STATUS, read-only.
    - [0] running (state ∈ HOLD/WAIT/RUN).
    - [1] done.
    - [2] error.
    - [3] raw `vx_busy`.
    - [6:4] state code.
    - [31:7] 0.
  - 0xFFFD CYCLES, read-only: run cycle counter.
  - 0xFFFC TIMEOUT, read/write: 0 disables the timeout.
  - Any other address reads 0; writes to it are ignored.
- FSM, with state codes:
  - IDLE (0): `vx_reset`=1. GO → HOLD; clears CYCLES, done, error; loads hold counter with RESET_HOLD.
  - HOLD (1): `vx_reset`=1. Decrements the hold counter; when it reaches 0 → WAIT.
  - WAIT (2): `vx_reset`=0. Counts the window. `vx_busy`=1 → RUN. Window reaches START_WIN with no busy → ERROR.
  - RUN (3): `vx_reset`=0. `vx_busy` low for 2 consecutive cycles → DONE.
  - DONE (4): `vx_reset`=1, done=1.
  - ERROR (5): `vx_reset`=1, error=1.
  - From any running state: TIMEOUT≠0 and CYCLES==TIMEOUT → ERROR.
- Exiting DONE and ERROR:
  - GO with CLR=0 starts a new run directly (→ HOLD).
  - CLR alone → IDLE.
  - GO and CLR together behave as GO.
- GO or CLR written while running (HOLD/WAIT/RUN) is ignored. No state or flag changes.
- CYCLES:
  - Increments each cycle in WAIT and RUN; holds its value otherwise.
  - Saturates at 0xFFFFFFFF.
  - Cleared only on GO.
- `host_mem_grant` = 1 in IDLE, DONE and ERROR; 0 otherwise.
- TIMEOUT writes take effect immediately, including mid-run.

## Timing
- Reset values (the cycle after `reset` is sampled low):
  - State IDLE, `vx_reset`=1, `host_mem_grant`=1.
  - `irq`=0, `reg_rvalid`=0, `reg_rdata`=0.
  - CYCLES=0, TIMEOUT=0, done=0, error=0.
- Reset mid-run: next edge returns to the full reset state; counters are discarded.
- GO write at edge N:
  - State=HOLD and `host_mem_grant`=0 at N+1.
  - `vx_reset` stays 1 for RESET_HOLD cycles (HOLD spans N+1 … N+RESET_HOLD).
  - `vx_reset` falls at N+RESET_HOLD+1, when WAIT is entered.
- WAIT→RUN: takes effect the cycle after `vx_busy` is sampled high.
- RUN→DONE: the second consecutive low sample of `vx_busy` moves the FSM to DONE on the following edge.
  - On that same edge `vx_reset`=1, `irq`=1 and `host_mem_grant`=1.
- Reads:
  - `reg_rdata` and `reg_rvalid` are valid at N+1 for a strobe at N.
  - A read returns register values as they were before that edge's updates.
- A write to STATUS, CYCLES or an unmapped address is a no-op.
- Simultaneous timeout match and busy drop: ERROR wins.

## Test plan
- Reset while HOLD: assert `reset`=0 for 1 cycle → state IDLE, `vx_reset`=1, `host_mem_grant`=1, CYCLES=0, TIMEOUT=0 on the next cycle.
- Nominal run, RESET_HOLD=8: write START=0x1, then `vx_busy` high 3 cycles after release for 100 cycles, then low.
  - `vx_reset` low exactly 8 cycles after GO takes effect.
  - DONE is entered 2 cycles after busy falls.
  - STATUS reads 0x42 (done, state 4); `irq`=1.
  - CYCLES = 3 + 100 + 2.
- No-start error: GO, `vx_busy` held 0 → ERROR after 16 WAIT cycles, STATUS=0x54, `irq`=1, `vx_reset`=1.
- Timeout: TIMEOUT=50, GO, `vx_busy` stuck 1 → ERROR when CYCLES=50; CYCLES then holds at 50.
- Ignored/clear writes:
  - GO during RUN → no change.
  - After DONE, write 0x2 → IDLE, `irq`=0, STATUS=0x0.
  - Write 0x3 from DONE → HOLD, CYCLES cleared.
- Register reads: read 0xFFFC after writing 0x1234 → `reg_rdata`=0x1234 with `reg_rvalid` at the next cycle; read 0xFFF0 → 0.
